// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core (IF and MEM stages), the arbiter and the memory array.
// The slave modport is the arbiter's view. The master modport is the core/memory side.
interface mem_arbiter_if #(
    parameter int MEM_AW = 6,
    parameter int ADDR_W = MEM_AW + 2
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_valid;
    logic              d_read;
    logic              d_write;
    logic [2:0]        d_funct3;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [31:0]       d_rdata;
    logic              d_done;
    logic              d_err;
    logic              stall;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  if_req, if_addr, d_read, d_write, d_funct3, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_valid, d_rdata, d_done, d_err, stall,
               mem_addr, mem_read, mem_write, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_read, d_write, d_funct3, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_valid, d_rdata, d_done, d_err, stall,
               mem_addr, mem_read, mem_write, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data accesses have priority over fetch.
// Sub-word stores are done as a read followed by a merged write (RMW_WR).
module mem_arbiter #(
    parameter int MEM_AW = 6,
    parameter int ADDR_W = MEM_AW + 2
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus
);
    typedef enum logic {IDLE = 1'b0, RMW_WR = 1'b1} state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t            state_q, state_d;
    logic [31:0]       hold_q;
    logic [ADDR_W-1:0] d_addr;
    logic [ADDR_W-1:0] if_addr;
    logic [MEM_AW-1:0] d_word;
    logic [MEM_AW-1:0] if_word;
    logic [1:0]        d_off;
    logic [2:0]        f3;
    logic              d_req;
    logic              acc_err;
    logic              rmw_start;
    logic              unused_if_lsb;

    assign d_addr        = bus.d_addr;
    assign if_addr       = bus.if_addr;
    assign d_word        = d_addr[ADDR_W-1:2];
    assign if_word       = if_addr[ADDR_W-1:2];
    assign d_off         = d_addr[1:0];
    assign f3            = bus.d_funct3;
    assign d_req         = bus.d_read | bus.d_write;
    assign unused_if_lsb = ^if_addr[1:0];

    // A store is legal only as SB/SH/SW. A load is legal only as LB/LH/LW/LBU/LHU.
    // H-type needs even addresses and W-type needs word-aligned addresses.
    function automatic logic access_illegal(input logic is_wr, input logic [2:0] fn,
                                            input logic [1:0] off);
        logic bad;
        if (is_wr)
            bad = !(fn == F3_B || fn == F3_H || fn == F3_W);
        else
            bad = (fn == 3'b011 || fn == 3'b110 || fn == 3'b111);
        if (fn[1:0] == 2'b01 && off[0])
            bad = 1'b1;
        if (fn[1:0] == 2'b10 && off != 2'b00)
            bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] fn,
                                                input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (fn)
            F3_B:    res = {{24{b[7]}}, b};
            F3_H:    res = {{16{h[15]}}, h};
            F3_BU:   res = {24'h0, b};
            F3_HU:   res = {16'h0, h};
            F3_W:    res = word;
            default: res = 32'h0;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [31:0] wdata,
                                               input logic [2:0] fn, input logic [1:0] off);
        logic [31:0] res;
        res = word;
        if (fn == F3_B)
            res[{off, 3'b000} +: 8] = wdata[7:0];
        else
            res[{off[1], 4'b0000} +: 16] = wdata[15:0];
        return res;
    endfunction

    assign acc_err   = access_illegal(bus.d_write, f3, d_off);
    assign rmw_start = d_req & bus.d_write & ~acc_err & (f3 == F3_B || f3 == F3_H);

    // State register; the hold word is captured on the read half of an RMW.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && rmw_start)
                hold_q <= bus.mem_rdata;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rmw_start) state_d = RMW_WR;
            RMW_WR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode. Every output is forced low while reset is high.
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_wdata = 32'h0;
        bus.d_rdata   = 32'h0;
        bus.d_done    = 1'b0;
        bus.d_err     = 1'b0;
        bus.if_rdata  = 32'h0;
        bus.if_valid  = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (d_req) begin
                        bus.mem_addr = d_word;
                        bus.d_done   = 1'b1;
                        if (acc_err) begin
                            bus.d_err = 1'b1;
                        end else if (bus.d_write) begin
                            if (f3 == F3_W) begin
                                bus.mem_write = 1'b1;
                                bus.mem_wdata = bus.d_wdata;
                            end else begin
                                bus.mem_read = 1'b1;
                                bus.d_done   = 1'b0;
                            end
                        end else begin
                            bus.mem_read = 1'b1;
                            bus.d_rdata  = load_extend(bus.mem_rdata, f3, d_off);
                        end
                    end else if (bus.if_req) begin
                        bus.mem_addr = if_word;
                        bus.mem_read = 1'b1;
                        bus.if_rdata = bus.mem_rdata;
                        bus.if_valid = 1'b1;
                    end
                end
                RMW_WR: begin
                    bus.mem_addr  = d_word;
                    bus.mem_write = 1'b1;
                    bus.mem_wdata = merge_lane(hold_q, bus.d_wdata, f3, d_off);
                    bus.d_done    = 1'b1;
                end
                default: ;
            endcase
        end
        bus.stall = ~rst & ((d_req & ~bus.d_done) | (bus.if_req & ~bus.if_valid));
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memory array and a scoreboard
// of expected read data.
module tb_mem_arbiter;
    localparam int MEM_AW = 6;
    localparam int ADDR_W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.MEM_AW(MEM_AW), .ADDR_W(ADDR_W)) bus ();

    mem_arbiter #(.MEM_AW(MEM_AW), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0]       mem [0:(1<<MEM_AW)-1];
    logic              pre_we;
    logic [MEM_AW-1:0] pre_addr;
    logic [31:0]       pre_data;

    always @(posedge clk) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (bus.mem_write)
            mem[bus.mem_addr] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = mem[bus.mem_addr];

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q [$];
    string       tag_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL sb_empty: got %h expected none", obs);
        end else begin
            chk(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    task automatic clear_in();
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.d_read   = 1'b0;
        bus.d_write  = 1'b0;
        bus.d_funct3 = 3'b000;
        bus.d_addr   = '0;
        bus.d_wdata  = 32'h0;
    endtask

    task automatic drive_d(input logic rd, input logic wr, input logic [2:0] fn,
                           input logic [ADDR_W-1:0] addr, input logic [31:0] wdata);
        bus.d_read   = rd;
        bus.d_write  = wr;
        bus.d_funct3 = fn;
        bus.d_addr   = addr;
        bus.d_wdata  = wdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]        fn;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       exp;
    } load_t;

    load_t loads [$];

    initial begin
        rst    = 1'b1;
        pre_we = 1'b0;
        pre_addr = '0;
        pre_data = 32'h0;
        clear_in();
        tick();

        // Preload while reset is held, with requests active to exercise output gating.
        for (int i = 0; i < (1 << MEM_AW); i++) begin
            pre_we   = 1'b1;
            pre_addr = MEM_AW'(i);
            pre_data = 32'hC0DE_0000 + 32'(i);
            tick();
        end
        pre_addr = 6'd1; pre_data = 32'h80FF_7F01; tick();
        pre_addr = 6'd2; pre_data = 32'h1122_3344; tick();
        pre_addr = 6'd4; pre_data = 32'h0BAD_F00D; tick();
        pre_we = 1'b0;

        bus.if_req = 1'b1;
        bus.if_addr = 8'h04;
        drive_d(1'b1, 1'b0, 3'b010, 8'h04, 32'h0);
        @(negedge clk);
        chk("rst_stall",    32'(bus.stall),     32'h0);
        chk("rst_d_done",   32'(bus.d_done),    32'h0);
        chk("rst_if_valid", 32'(bus.if_valid),  32'h0);
        chk("rst_mem_read", 32'(bus.mem_read),  32'h0);
        chk("rst_d_rdata",  bus.d_rdata,        32'h0);
        chk("rst_if_rdata", bus.if_rdata,       32'h0);
        tick();
        rst = 1'b0;
        clear_in();

        // Loads with sign/zero extension, all single-cycle.
        loads.push_back('{3'b000, 8'h04, 32'h0000_0001});
        loads.push_back('{3'b000, 8'h06, 32'hFFFF_FFFF});
        loads.push_back('{3'b100, 8'h06, 32'h0000_00FF});
        loads.push_back('{3'b001, 8'h06, 32'hFFFF_80FF});
        loads.push_back('{3'b101, 8'h06, 32'h0000_80FF});
        loads.push_back('{3'b001, 8'h04, 32'h0000_7F01});
        loads.push_back('{3'b010, 8'h04, 32'h80FF_7F01});
        foreach (loads[i]) begin
            drive_d(1'b1, 1'b0, loads[i].fn, loads[i].addr, 32'h0);
            push_exp($sformatf("load%0d", i), loads[i].exp);
            @(negedge clk);
            chk($sformatf("load%0d_done", i),  32'(bus.d_done), 32'h1);
            chk($sformatf("load%0d_stall", i), 32'(bus.stall),  32'h0);
            pop_chk(bus.d_rdata);
            tick();
        end
        clear_in();

        // SB read-modify-write; upper wdata bits must be ignored.
        drive_d(1'b0, 1'b1, 3'b000, 8'h09, 32'hFFFF_FFAB);
        @(negedge clk);
        chk("sb_c1_read",  32'(bus.mem_read),  32'h1);
        chk("sb_c1_write", 32'(bus.mem_write), 32'h0);
        chk("sb_c1_stall", 32'(bus.stall),     32'h1);
        chk("sb_c1_done",  32'(bus.d_done),    32'h0);
        tick();
        @(negedge clk);
        chk("sb_c2_write", 32'(bus.mem_write), 32'h1);
        chk("sb_c2_wdata", bus.mem_wdata,      32'h1122_AB44);
        chk("sb_c2_done",  32'(bus.d_done),    32'h1);
        chk("sb_c2_stall", 32'(bus.stall),     32'h0);
        tick();
        drive_d(1'b1, 1'b0, 3'b010, 8'h08, 32'h0);
        push_exp("sb_readback", 32'h1122_AB44);
        @(negedge clk);
        pop_chk(bus.d_rdata);
        tick();
        clear_in();

        // Fetch collides with LW: data first, fetch one cycle later.
        bus.if_req = 1'b1;
        bus.if_addr = 8'h05;
        drive_d(1'b1, 1'b0, 3'b010, 8'h10, 32'h0);
        push_exp("coll_lw", 32'h0BAD_F00D);
        @(negedge clk);
        pop_chk(bus.d_rdata);
        chk("coll_if_valid0", 32'(bus.if_valid), 32'h0);
        chk("coll_stall0",    32'(bus.stall),    32'h1);
        tick();
        drive_d(1'b0, 1'b0, 3'b000, 8'h00, 32'h0);
        push_exp("coll_fetch", 32'h80FF_7F01);
        @(negedge clk);
        chk("coll_if_valid1", 32'(bus.if_valid), 32'h1);
        chk("coll_stall1",    32'(bus.stall),    32'h0);
        pop_chk(bus.if_rdata);
        tick();

        // Fetch behind SH waits two cycles.
        drive_d(1'b0, 1'b1, 3'b001, 8'h12, 32'h9999_5566);
        @(negedge clk);
        chk("sh_if_valid0", 32'(bus.if_valid), 32'h0);
        chk("sh_stall0",    32'(bus.stall),    32'h1);
        tick();
        @(negedge clk);
        chk("sh_if_valid1", 32'(bus.if_valid), 32'h0);
        chk("sh_done1",     32'(bus.d_done),   32'h1);
        chk("sh_wdata1",    bus.mem_wdata,     32'h5566_F00D);
        chk("sh_stall1",    32'(bus.stall),    32'h1);
        tick();
        drive_d(1'b0, 1'b0, 3'b000, 8'h00, 32'h0);
        push_exp("sh_fetch", 32'h80FF_7F01);
        @(negedge clk);
        chk("sh_if_valid2", 32'(bus.if_valid), 32'h1);
        pop_chk(bus.if_rdata);
        chk("sh_mem4", mem[4], 32'h5566_F00D);
        tick();
        clear_in();

        // Misaligned and illegal accesses.
        drive_d(1'b1, 1'b0, 3'b010, 8'h05, 32'h0);
        @(negedge clk);
        chk("lw_mis_err",  32'(bus.d_err),                    32'h1);
        chk("lw_mis_done", 32'(bus.d_done),                   32'h1);
        chk("lw_mis_strb", 32'({bus.mem_read, bus.mem_write}), 32'h0);
        chk("lw_mis_data", bus.d_rdata,                       32'h0);
        chk("lw_mis_stall", 32'(bus.stall),                   32'h0);
        tick();
        drive_d(1'b0, 1'b1, 3'b001, 8'h03, 32'h0000_1234);
        @(negedge clk);
        chk("sh_mis_err",   32'(bus.d_err),     32'h1);
        chk("sh_mis_write", 32'(bus.mem_write), 32'h0);
        tick();
        clear_in();
        @(negedge clk);
        chk("sh_mis_mem0",  mem[0],             32'hC0DE_0000);
        chk("sh_mis_idle",  32'(bus.mem_write), 32'h0);
        tick();
        drive_d(1'b1, 1'b0, 3'b011, 8'h00, 32'h0);
        @(negedge clk);
        chk("ld_f3_err",  32'(bus.d_err),    32'h1);
        chk("ld_f3_read", 32'(bus.mem_read), 32'h0);
        tick();
        drive_d(1'b0, 1'b1, 3'b100, 8'h00, 32'h0);
        @(negedge clk);
        chk("st_f3_err", 32'(bus.d_err), 32'h1);
        tick();
        clear_in();

        // Reset during the write half of an SB abandons the write.
        drive_d(1'b0, 1'b1, 3'b000, 8'h08, 32'h0000_0077);
        @(negedge clk);
        chk("rmw_rst_c1_read", 32'(bus.mem_read), 32'h1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rmw_rst_write", 32'(bus.mem_write), 32'h0);
        chk("rmw_rst_done",  32'(bus.d_done),    32'h0);
        chk("rmw_rst_stall", 32'(bus.stall),     32'h0);
        chk("rmw_rst_wdata", bus.mem_wdata,      32'h0);
        tick();
        rst = 1'b0;
        clear_in();
        bus.if_req = 1'b1;
        bus.if_addr = 8'h08;
        push_exp("rmw_rst_fetch", 32'h1122_AB44);
        @(negedge clk);
        chk("rmw_rst_idle", 32'(bus.if_valid), 32'h1);
        pop_chk(bus.if_rdata);
        chk("rmw_rst_mem2", mem[2], 32'h1122_AB44);
        tick();
        clear_in();

        // SW then LW at the last word.
        drive_d(1'b0, 1'b1, 3'b010, 8'hFC, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("sw_write", 32'(bus.mem_write), 32'h1);
        chk("sw_addr",  32'(bus.mem_addr),  32'd63);
        chk("sw_wdata", bus.mem_wdata,      32'hDEAD_BEEF);
        chk("sw_done",  32'(bus.d_done),    32'h1);
        chk("sw_stall", 32'(bus.stall),     32'h0);
        tick();
        drive_d(1'b1, 1'b0, 3'b010, 8'hFC, 32'h0);
        push_exp("lw_last", 32'hDEAD_BEEF);
        @(negedge clk);
        chk("lw_last_done", 32'(bus.d_done), 32'h1);
        pop_chk(bus.d_rdata);
        tick();
        clear_in();

        chk("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
